// File: rtl/arbl2dr_rr_pkg.sv
// Beat formats exchanged between the L2 data caches and the directory, plus the
// default position of the port index inside nid.
package arbl2dr_rr_pkg;

   localparam int unsigned ARB_NID_LSB = 3;

   typedef struct packed {
      logic [4:0]  nid;
      logic [31:0] paddr;
      logic [2:0]  cmd;
   } I_l2todr_req_type;

   typedef struct packed {
      logic [4:0]  nid;
      logic [5:0]  l2id;
      logic [31:0] data;
   } I_drtol2_snack_type;

endpackage

// File: rtl/arb_skid2.sv
// Two-entry valid/retry FIFO. Retry comes straight from the registered count so
// no combinational path links the downstream retry to the upstream retry.
module arb_skid2 #(
   parameter int unsigned Size = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_retry,
   input  logic [Size-1:0] in_data,
   output logic            out_valid,
   input  logic            out_retry,
   output logic [Size-1:0] out_data
);

   logic [Size-1:0] mem_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic            push;
   logic            pop;

   assign in_retry  = count_q[1];
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid && !in_retry;
   assign pop       = out_valid && !out_retry;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q        <= !wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
         if (push && !pop) begin
            count_q <= count_q + 2'd1;
         end else if (pop && !push) begin
            count_q <= count_q - 2'd1;
         end
      end
   end

endmodule

// File: rtl/arbl2dr_rr.sv
// Round-robin merge of per-core L2 requests toward the directory (source port
// stamped into nid) and nid-decoded fan-out of directory snacks back to the L2s.
module arbl2dr_rr
   import arbl2dr_rr_pkg::*;
#(
   parameter int unsigned NPORTS    = 4,
   parameter int unsigned PORT_BITS = 2,
   parameter int unsigned NID_LSB   = ARB_NID_LSB
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NPORTS-1:0]  l2todr_req_in_valid,
   output logic [NPORTS-1:0]  l2todr_req_in_retry,
   input  I_l2todr_req_type   l2todr_req_in [NPORTS],
   output logic               l2todr_req_valid,
   input  logic               l2todr_req_retry,
   output I_l2todr_req_type   l2todr_req,
   input  logic               drtol2_snack_valid,
   output logic               drtol2_snack_retry,
   input  I_drtol2_snack_type drtol2_snack,
   output logic [NPORTS-1:0]  drtol2_snack_out_valid,
   input  logic [NPORTS-1:0]  drtol2_snack_out_retry,
   output I_drtol2_snack_type drtol2_snack_out [NPORTS],
   output logic               err_badnid
);

   localparam int unsigned NSLOTS = 1 << PORT_BITS;
   localparam int unsigned REQ_W  = $bits(I_l2todr_req_type);
   localparam int unsigned SNK_W  = $bits(I_drtol2_snack_type);

   // Request path
   logic [NSLOTS-1:0]    req_valid_ext;
   I_l2todr_req_type     req_ext [NSLOTS];
   logic [PORT_BITS-1:0] last_q;
   logic [PORT_BITS-1:0] grant_idx;
   logic [PORT_BITS-1:0] cand;
   logic                 grant_any;
   logic                 req_full;
   logic                 req_push;
   I_l2todr_req_type     req_stamped;

   always_comb begin
      req_valid_ext = '0;
      for (int p = 0; p < NSLOTS; p++) begin
         req_ext[p] = '0;
      end
      for (int p = 0; p < NPORTS; p++) begin
         req_valid_ext[p] = l2todr_req_in_valid[p];
         req_ext[p]       = l2todr_req_in[p];
      end

      // First valid port after the last winner, wrapping modulo NPORTS.
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NPORTS; i++) begin
         cand = PORT_BITS'((32'(last_q) + i) % NPORTS);
         if (!grant_any && req_valid_ext[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end

      req_stamped = req_ext[grant_idx];
      req_stamped.nid[NID_LSB +: PORT_BITS] = grant_idx;
      req_push = grant_any && !req_full;

      l2todr_req_in_retry = '0;
      for (int p = 0; p < NPORTS; p++) begin
         l2todr_req_in_retry[p] = l2todr_req_in_valid[p] &&
                                  (req_full || (PORT_BITS'(p) != grant_idx));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= PORT_BITS'(NPORTS - 1);
      end else if (req_push) begin
         last_q <= grant_idx;
      end
   end

   arb_skid2 #(
      .Size (REQ_W)
   ) u_req_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (req_push),
      .in_retry  (req_full),
      .in_data   (req_stamped),
      .out_valid (l2todr_req_valid),
      .out_retry (l2todr_req_retry),
      .out_data  (l2todr_req)
   );

   // Snack path
   logic [PORT_BITS-1:0] snk_idx;
   logic                 snk_bad;
   logic [NSLOTS-1:0]    snk_full_ext;
   logic [NPORTS-1:0]    snk_full;
   logic [NPORTS-1:0]    snk_push;
   logic                 err_badnid_q;

   assign snk_idx = drtol2_snack.nid[NID_LSB +: PORT_BITS];

   always_comb begin
      snk_bad      = (32'(snk_idx) >= NPORTS);
      snk_full_ext = '0;
      snk_push     = '0;
      for (int p = 0; p < NPORTS; p++) begin
         snk_full_ext[p] = snk_full[p];
         snk_push[p]     = drtol2_snack_valid && !snk_bad && (snk_idx == PORT_BITS'(p));
      end
      // Out-of-range snacks are swallowed so they cannot wedge the directory.
      drtol2_snack_retry = !snk_bad && snk_full_ext[snk_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_badnid_q <= 1'b0;
      end else if (drtol2_snack_valid && snk_bad) begin
         err_badnid_q <= 1'b1;
      end
   end

   assign err_badnid = err_badnid_q;

   for (genvar p = 0; p < NPORTS; p++) begin : g_snk
      arb_skid2 #(
         .Size (SNK_W)
      ) u_snk_skid (
         .clk       (clk),
         .reset     (reset),
         .in_valid  (snk_push[p]),
         .in_retry  (snk_full[p]),
         .in_data   (drtol2_snack),
         .out_valid (drtol2_snack_out_valid[p]),
         .out_retry (drtol2_snack_out_retry[p]),
         .out_data  (drtol2_snack_out[p])
      );
   end

endmodule

// File: tb/tb_arbl2dr_rr.sv
// Directed bench for arbl2dr_rr: a 4-port instance with scoreboarded outputs and
// a 3-port instance for the out-of-range snack index.
module tb_arbl2dr_rr;
   import arbl2dr_rr_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // 4-port instance
   logic [3:0]         req_in_valid, req_in_retry;
   I_l2todr_req_type   req_in [4];
   logic               req_valid, req_retry;
   I_l2todr_req_type   req_out;
   logic               snk_valid, snk_retry;
   I_drtol2_snack_type snk_in;
   logic [3:0]         snk_out_valid, snk_out_retry;
   I_drtol2_snack_type snk_out [4];
   logic               err;

   // 3-port instance
   logic [2:0]         r3_valid, r3_retry;
   I_l2todr_req_type   r3_in [3];
   logic               r3_ovalid, r3_oretry;
   I_l2todr_req_type   r3_out;
   logic               s3_valid, s3_retry;
   I_drtol2_snack_type s3_in;
   logic [2:0]         s3_ovalid, s3_oretry;
   I_drtol2_snack_type s3_out [3];
   logic               err3;

   arbl2dr_rr #(.NPORTS(4), .PORT_BITS(2), .NID_LSB(3)) dut (
      .clk(clk), .reset(reset),
      .l2todr_req_in_valid(req_in_valid), .l2todr_req_in_retry(req_in_retry),
      .l2todr_req_in(req_in),
      .l2todr_req_valid(req_valid), .l2todr_req_retry(req_retry), .l2todr_req(req_out),
      .drtol2_snack_valid(snk_valid), .drtol2_snack_retry(snk_retry), .drtol2_snack(snk_in),
      .drtol2_snack_out_valid(snk_out_valid), .drtol2_snack_out_retry(snk_out_retry),
      .drtol2_snack_out(snk_out), .err_badnid(err)
   );

   arbl2dr_rr #(.NPORTS(3), .PORT_BITS(2), .NID_LSB(3)) dut3 (
      .clk(clk), .reset(reset),
      .l2todr_req_in_valid(r3_valid), .l2todr_req_in_retry(r3_retry),
      .l2todr_req_in(r3_in),
      .l2todr_req_valid(r3_ovalid), .l2todr_req_retry(r3_oretry), .l2todr_req(r3_out),
      .drtol2_snack_valid(s3_valid), .drtol2_snack_retry(s3_retry), .drtol2_snack(s3_in),
      .drtol2_snack_out_valid(s3_ovalid), .drtol2_snack_out_retry(s3_oretry),
      .drtol2_snack_out(s3_out), .err_badnid(err3)
   );

   int checks = 0;
   int errors = 0;

   I_l2todr_req_type   req_q [$];
   I_drtol2_snack_type snk_q [4][$];
   I_l2todr_req_type   cur_req [4];
   I_drtol2_snack_type cur_snk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic I_l2todr_req_type new_req();
      I_l2todr_req_type r;
      r.nid   = 5'($urandom);
      r.paddr = $urandom;
      r.cmd   = 3'($urandom);
      return r;
   endfunction

   function automatic I_drtol2_snack_type new_snk();
      I_drtol2_snack_type s;
      s.nid  = 5'($urandom);
      s.l2id = 6'($urandom);
      s.data = $urandom;
      return s;
   endfunction

   function automatic I_l2todr_req_type stamp(input I_l2todr_req_type r, input int p);
      I_l2todr_req_type s;
      s = r;
      s.nid[4:3] = 2'(p);
      return s;
   endfunction

   // Scoreboard: with nothing expected an output must be idle; otherwise each
   // accepted beat must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (req_q.size() == 0) begin
            chk("req_idle", 64'(req_valid), 64'(0));
         end else if (req_valid && !req_retry) begin
            chk("req_data", 64'(req_out), 64'(req_q.pop_front()));
         end
         for (int p = 0; p < 4; p++) begin
            if (snk_q[p].size() == 0) begin
               chk("snk_idle", 64'(snk_out_valid[p]), 64'(0));
            end else if (snk_out_valid[p] && !snk_out_retry[p]) begin
               chk("snk_data", 64'(snk_out[p]), 64'(snk_q[p].pop_front()));
            end
         end
      end
   end

   task automatic req_cycle(input logic [3:0] v, input logic dr, input logic [3:0] exp_retry,
                            input string tag);
      @(posedge clk); #1;
      req_in_valid = v;
      req_retry    = dr;
      for (int p = 0; p < 4; p++) req_in[p] = cur_req[p];
      @(negedge clk); #1;
      chk(tag, 64'(req_in_retry), 64'(exp_retry));
      for (int p = 0; p < 4; p++) begin
         if (v[p] && !exp_retry[p]) begin
            req_q.push_back(stamp(cur_req[p], p));
            cur_req[p] = new_req();
         end
      end
   endtask

   task automatic snk_cycle(input logic v, input logic [1:0] idx, input logic [3:0] oretry,
                            input logic exp_retry, input string tag);
      @(posedge clk); #1;
      cur_snk.nid[4:3] = idx;
      snk_valid     = v;
      snk_out_retry = oretry;
      snk_in        = cur_snk;
      @(negedge clk); #1;
      chk(tag, 64'(snk_retry), 64'(exp_retry));
      if (v && !exp_retry) begin
         snk_q[idx].push_back(cur_snk);
         cur_snk = new_snk();
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         req_in_valid = '0;
         snk_valid    = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      req_in_valid = '0; req_retry = 1'b0;
      snk_valid = 1'b0; snk_out_retry = '0;
      r3_valid = '0; r3_oretry = 1'b0; s3_valid = 1'b0; s3_oretry = '0;
      for (int p = 0; p < 3; p++) r3_in[p] = '0;
      for (int p = 0; p < 4; p++) begin
         cur_req[p] = new_req();
         req_in[p]  = cur_req[p];
      end
      cur_req[1].nid = 5'b11010;
      cur_snk = new_snk();
      snk_in  = cur_snk;
      s3_in   = '0;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk); #1;
      chk("rst_req_valid", 64'(req_valid), 64'(0));
      chk("rst_snk_valid", 64'(snk_out_valid), 64'(0));
      chk("rst_req_retry", 64'(req_in_retry), 64'(0));
      chk("rst_snk_retry", 64'(snk_retry), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_err3", 64'(err3), 64'(0));

      // All ports valid: grants rotate 0,1,2,3,0,...
      for (int k = 0; k < 8; k++) begin
         req_cycle(4'hF, 1'b0, 4'(4'hF ^ (4'b0001 << (k % 4))), "rr_all");
      end
      idle(3);

      // Port 2 alone against a 3-cycle directory retry.
      req_cycle(4'b0100, 1'b1, 4'b0000, "p2_c0");
      req_cycle(4'b0100, 1'b1, 4'b0000, "p2_c1");
      chk("req_latency", 64'(req_valid), 64'(1));
      req_cycle(4'b0100, 1'b1, 4'b0100, "p2_full");
      req_cycle(4'b0100, 1'b0, 4'b0100, "p2_full_pop");
      req_cycle(4'b0100, 1'b0, 4'b0000, "p2_resume");
      idle(3);

      // Ports 1 and 3 only, last winner was 2.
      req_cycle(4'b1010, 1'b0, 4'b0010, "rr_skip_3");
      req_cycle(4'b1010, 1'b0, 4'b1000, "rr_skip_1");
      req_cycle(4'b1010, 1'b0, 4'b0010, "rr_skip_3b");
      req_cycle(4'b1010, 1'b0, 4'b1000, "rr_skip_1b");
      idle(3);

      // Snacks while port 0 is stalled.
      snk_cycle(1'b1, 2'd0, 4'b0001, 1'b0, "snk_p0_a");
      snk_cycle(1'b1, 2'd3, 4'b0001, 1'b0, "snk_p3");
      snk_cycle(1'b1, 2'd0, 4'b0001, 1'b0, "snk_p0_b");
      chk("snk_latency", 64'(snk_out_valid), 64'(4'b1001));
      snk_cycle(1'b1, 2'd2, 4'b0001, 1'b0, "snk_p2_indep");
      snk_cycle(1'b1, 2'd0, 4'b0001, 1'b1, "snk_p0_full");
      snk_cycle(1'b1, 2'd0, 4'b0000, 1'b1, "snk_full_pop");
      snk_cycle(1'b1, 2'd0, 4'b0000, 1'b0, "snk_p0_resume");
      idle(4);

      // 3-port instance: index 2 is delivered, index 3 is dropped and flagged.
      @(posedge clk); #1;
      s3_in = new_snk(); s3_in.nid[4:3] = 2'd2; s3_valid = 1'b1;
      @(posedge clk); #1;
      s3_in = new_snk(); s3_in.nid[4:3] = 2'd3;
      @(negedge clk); #1;
      chk("s3_good_valid", 64'(s3_ovalid), 64'(3'b100));
      chk("s3_bad_retry", 64'(s3_retry), 64'(0));
      @(posedge clk); #1;
      s3_valid = 1'b0;
      @(negedge clk); #1;
      chk("s3_bad_novalid", 64'(s3_ovalid), 64'(0));
      chk("s3_bad_err", 64'(err3), 64'(1));
      repeat (3) @(posedge clk);
      #1;
      chk("s3_err_sticky", 64'(err3), 64'(1));

      // Fill both paths, then reset.
      snk_cycle(1'b1, 2'd0, 4'b0001, 1'b0, "fill_snk_a");
      snk_cycle(1'b1, 2'd0, 4'b0001, 1'b0, "fill_snk_b");
      snk_cycle(1'b1, 2'd0, 4'b0001, 1'b1, "fill_snk_full");
      req_cycle(4'b0001, 1'b1, 4'b0000, "fill_req_a");
      req_cycle(4'b0001, 1'b1, 4'b0000, "fill_req_b");
      req_cycle(4'b0001, 1'b1, 4'b0001, "fill_req_full");
      @(posedge clk); #1;
      reset = 1'b1;
      req_in_valid = '0;
      snk_valid = 1'b0;
      req_q.delete();
      for (int p = 0; p < 4; p++) snk_q[p].delete();
      @(posedge clk); #1;
      reset = 1'b0;
      req_retry = 1'b0;
      snk_out_retry = '0;
      @(negedge clk); #1;
      chk("rst2_req_valid", 64'(req_valid), 64'(0));
      chk("rst2_snk_valid", 64'(snk_out_valid), 64'(0));
      chk("rst2_snk_retry", 64'(snk_retry), 64'(0));
      chk("rst2_err3", 64'(err3), 64'(0));
      req_cycle(4'hF, 1'b0, 4'hE, "rst2_p0_first");
      req_cycle(4'hF, 1'b0, 4'hD, "rst2_p1_next");
      idle(4);

      chk("req_drained", 64'(req_q.size()), 64'(0));
      for (int p = 0; p < 4; p++) chk("snk_drained", 64'(snk_q[p].size()), 64'(0));
      chk("err_clean", 64'(err), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
